// File: rtl/cfu_li2_initiator.sv
// ============================================================================
// cfu_li2_initiator : single-outstanding CFU request initiator with timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfu_li2_initiator #(
    parameter int CFU_FUNC_ID_W     = 1,
    parameter int CFU_REQ_RESP_ID_W = 8,
    parameter int CFU_REQ_DATA_W    = 32,
    parameter int CFU_RESP_DATA_W   = 32,
    parameter int CFU_ERR_ID_W      = 32,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [CFU_FUNC_ID_W-1:0]     cmd_func_id,
    input  logic [CFU_REQ_DATA_W-1:0]    cmd_data0,
    input  logic [CFU_REQ_DATA_W-1:0]    cmd_data1,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [CFU_FUNC_ID_W-1:0]     req_func_id,
    output logic [CFU_REQ_RESP_ID_W-1:0] req_id,
    output logic [CFU_REQ_DATA_W-1:0]    req_data0,
    output logic [CFU_REQ_DATA_W-1:0]    req_data1,
    input  logic                         resp_valid,
    input  logic [CFU_REQ_RESP_ID_W-1:0] resp_id,
    input  logic [CFU_RESP_DATA_W-1:0]   resp_data,
    input  logic                         resp_err,
    input  logic [CFU_ERR_ID_W-1:0]      resp_err_id,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [CFU_RESP_DATA_W-1:0]   res_data,
    output logic                         res_err,
    output logic [CFU_ERR_ID_W-1:0]      res_err_id,
    output logic                         res_timeout,
    output logic                         res_id_mismatch,
    output logic                         stray_resp
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] C_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CFU_FUNC_ID_W-1:0]       r_func_id;
    logic [CFU_REQ_DATA_W-1:0]      r_data0;
    logic [CFU_REQ_DATA_W-1:0]      r_data1;
    logic [CFU_REQ_RESP_ID_W-1:0]   r_next_id;
    logic [CFU_REQ_RESP_ID_W-1:0]   r_issued_id;
    logic [15:0]                    r_timer;
    logic [CFU_RESP_DATA_W-1:0]     r_res_data;
    logic                           r_res_err;
    logic [CFU_ERR_ID_W-1:0]        r_res_err_id;
    logic                           r_res_timeout;
    logic                           r_res_mismatch;
    logic                           r_stray;

    logic w_cmd_fire;
    logic w_req_fire;
    logic w_resp_hit;
    logic w_timeout;

    assign w_cmd_fire = cmd_valid && (r_state == ST_IDLE);
    assign w_req_fire = (r_state == ST_ISSUE) && req_ready;
    assign w_resp_hit = (r_state == ST_WAIT) && resp_valid;
    // A response arriving on the last timer cycle takes priority over the timeout.
    assign w_timeout  = (r_state == ST_WAIT) && !resp_valid && (r_timer == C_TIMER_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (cmd_valid)               w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (req_ready)               w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_resp_hit || w_timeout) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (res_ready)               w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_func_id      <= '0;
            r_data0        <= '0;
            r_data1        <= '0;
            r_next_id      <= '0;
            r_issued_id    <= '0;
            r_timer        <= '0;
            r_res_data     <= '0;
            r_res_err      <= 1'b0;
            r_res_err_id   <= '0;
            r_res_timeout  <= 1'b0;
            r_res_mismatch <= 1'b0;
            r_stray        <= 1'b0;
        end else begin
            r_stray <= resp_valid && (r_state != ST_WAIT);
            if (w_cmd_fire) begin
                r_func_id <= cmd_func_id;
                r_data0   <= cmd_data0;
                r_data1   <= cmd_data1;
            end
            if (w_req_fire) begin
                r_issued_id <= r_next_id;
                r_next_id   <= r_next_id + CFU_REQ_RESP_ID_W'(1);
                r_timer     <= '0;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer + 16'd1;
            end
            if (w_resp_hit) begin
                r_res_data     <= resp_data;
                r_res_err      <= resp_err;
                r_res_err_id   <= resp_err_id;
                r_res_timeout  <= 1'b0;
                r_res_mismatch <= (resp_id != r_issued_id);
            end else if (w_timeout) begin
                r_res_data     <= '0;
                r_res_err      <= 1'b0;
                r_res_err_id   <= '0;
                r_res_timeout  <= 1'b1;
                r_res_mismatch <= 1'b0;
            end
        end
    end

    assign cmd_ready       = (r_state == ST_IDLE);
    assign req_valid       = (r_state == ST_ISSUE);
    assign req_func_id     = r_func_id;
    assign req_id          = r_next_id;
    assign req_data0       = r_data0;
    assign req_data1       = r_data1;
    assign res_valid       = (r_state == ST_HOLD);
    assign res_data        = r_res_data;
    assign res_err         = r_res_err;
    assign res_err_id      = r_res_err_id;
    assign res_timeout     = r_res_timeout;
    assign res_id_mismatch = r_res_mismatch;
    assign stray_resp      = r_stray;

endmodule

`default_nettype wire

// File: tb/tb_cfu_li2_initiator.sv
// ============================================================================
// tb_cfu_li2_initiator : scoreboard bench for cfu_li2_initiator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cfu_li2_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [0:0]  cmd_func_id;
    logic [31:0] cmd_data0, cmd_data1;
    logic        req_valid, req_ready;
    logic [0:0]  req_func_id;
    logic [7:0]  req_id;
    logic [31:0] req_data0, req_data1;
    logic        resp_valid;
    logic [7:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] resp_err_id;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic [31:0] res_err_id;
    logic        res_timeout, res_id_mismatch, stray_resp;

    cfu_li2_initiator #(
        .CFU_FUNC_ID_W     (1),
        .CFU_REQ_RESP_ID_W (8),
        .CFU_REQ_DATA_W    (32),
        .CFU_RESP_DATA_W   (32),
        .CFU_ERR_ID_W      (32),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_func_id     (cmd_func_id),
        .cmd_data0       (cmd_data0),
        .cmd_data1       (cmd_data1),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_func_id     (req_func_id),
        .req_id          (req_id),
        .req_data0       (req_data0),
        .req_data1       (req_data1),
        .resp_valid      (resp_valid),
        .resp_id         (resp_id),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .resp_err_id     (resp_err_id),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_err         (res_err),
        .res_err_id      (res_err_id),
        .res_timeout     (res_timeout),
        .res_id_mismatch (res_id_mismatch),
        .stray_resp      (stray_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] err_id;
        logic        timeout;
        logic        mismatch;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [7:0]  model_id = 8'd0;
    bit          rsp_fixed = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: echoed response, 1: silent responder, 2: wrong ID with error
    task automatic run_cmd(input logic [0:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input int mode, input bit chk_lat);
        exp_t        e;
        exp_t        got;
        int          t0;
        int          n;
        logic [31:0] rd;
        logic [7:0]  iid;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        rd = rsp_fixed ? 32'd7 : a + b;
        e.data = rd; e.err = 1'b0; e.err_id = 32'd0; e.timeout = 1'b0; e.mismatch = 1'b0;
        if (mode == 1) begin
            e.data = 32'd0; e.timeout = 1'b1;
        end else if (mode == 2) begin
            e.err = 1'b1; e.err_id = 32'd5; e.mismatch = 1'b1;
        end
        sb.push_back(e);
        cmd_valid = 1'b1; cmd_func_id = f; cmd_data0 = a; cmd_data1 = b;
        req_ready = (stall == 0);
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_func_id = ~f; cmd_data0 = $urandom; cmd_data1 = $urandom;
        for (int i = 0; i <= stall; i++) begin
            check("req_valid_issue", {31'd0, req_valid}, 32'd1);
            check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            check("req_id", {24'd0, req_id}, {24'd0, model_id});
            check("req_func_id", {31'd0, req_func_id}, {31'd0, f});
            check("req_data0", req_data0, a);
            check("req_data1", req_data1, b);
            if (i == stall) req_ready = 1'b1;
            @(negedge clk);
        end
        req_ready = 1'b0;
        iid = model_id;
        model_id = model_id + 8'd1;
        check("req_valid_wait", {31'd0, req_valid}, 32'd0);
        if (mode == 1) begin
            n = 0;
            while (!res_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, 32'd8);
        end else begin
            resp_valid = 1'b1; resp_data = rd;
            resp_id = (mode == 2) ? iid + 8'd1 : iid;
            resp_err = (mode == 2); resp_err_id = (mode == 2) ? 32'd5 : 32'd0;
            @(negedge clk);
            resp_valid = 1'b0;
        end
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("stray_in_hold", {31'd0, stray_resp}, 32'd0);
        if (chk_lat) check("latency", cyc - t0, 32'd3);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("res_data", res_data, got.data);
            check("res_err", {31'd0, res_err}, {31'd0, got.err});
            check("res_err_id", res_err_id, got.err_id);
            check("res_timeout", {31'd0, res_timeout}, {31'd0, got.timeout});
            check("res_id_mismatch", {31'd0, res_id_mismatch}, {31'd0, got.mismatch});
        end else begin
            check("sb_underflow", sb.size(), 32'd1);
        end
        if (mode == 1) begin
            resp_valid = 1'b1; resp_id = iid; resp_data = 32'h99; resp_err = 1'b1;
            @(negedge clk);
            resp_valid = 1'b0; resp_err = 1'b0;
            check("late_stray", {31'd0, stray_resp}, 32'd1);
            check("late_res_data", res_data, 32'd0);
            check("late_res_err", {31'd0, res_err}, 32'd0);
            check("late_res_timeout", {31'd0, res_timeout}, 32'd1);
            check("late_res_valid", {31'd0, res_valid}, 32'd1);
        end
        res_ready = 1'b1;
        check("cmd_ready_hold", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_cleared", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_func_id = '0; cmd_data0 = '0; cmd_data1 = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_id = '0; resp_data = '0;
        resp_err = 1'b0; resp_err_id = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_req_id", {24'd0, req_id}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(1'b0, 32'd14, 32'd21, 0, 0, 1'b1);
        run_cmd(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5, 0, 1'b0);
        run_cmd(1'b0, 32'd3, 32'd4, 0, 1, 1'b0);
        run_cmd(1'b1, 32'd9, 32'd10, 1, 2, 1'b0);

        cmd_valid = 1'b1; cmd_func_id = 1'b1; cmd_data0 = 32'hA5; cmd_data1 = 32'h5A;
        @(negedge clk);
        cmd_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_req_valid", {31'd0, req_valid}, 32'd0);
        check("arst_res_valid", {31'd0, res_valid}, 32'd0);
        check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_req_id", {24'd0, req_id}, 32'd0);
        check("arst_req_data0", req_data0, 32'd0);
        check("arst_res_err", {31'd0, res_err}, 32'd0);
        check("arst_res_mismatch", {31'd0, res_id_mismatch}, 32'd0);
        check("arst_res_err_id", res_err_id, 32'd0);
        check("arst_res_data", res_data, 32'd0);
        check("arst_res_timeout", {31'd0, res_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_id = 8'd0;
        resp_valid = 1'b1; resp_id = 8'd1; resp_data = 32'h55;
        @(negedge clk);
        resp_valid = 1'b0;
        check("post_rst_stray", {31'd0, stray_resp}, 32'd1);
        check("post_rst_res_data", res_data, 32'd0);
        @(negedge clk);
        check("stray_one_cycle", {31'd0, stray_resp}, 32'd0);

        rsp_fixed = 1'b0;
        for (int i = 0; i < 257; i++) begin
            run_cmd(i[0], $urandom, $urandom, 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cfu_li2_initiator.md
CFU_LI2_INITIATOR -- requirements
Module: cfu_li2_initiator

Interface
REQ-001 The block SHALL have parameter CFU_FUNC_ID_W, default 1, function ID width.
REQ-002 The block SHALL have parameter CFU_REQ_RESP_ID_W, default 8, request/response ID width.
REQ-003 The block SHALL have parameter CFU_REQ_DATA_W, default 32, request operand width.
REQ-004 The block SHALL have parameter CFU_RESP_DATA_W, default 32, response data width.
REQ-005 The block SHALL have parameter CFU_ERR_ID_W, default 32, error ID width.
REQ-006 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, WAIT-state cycle limit, range 2..65535.
REQ-007 The block SHALL have one clock and an asynchronous, active-high reset, named as follows:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  host command accepted
- cmd_func_id  in  CFU_FUNC_ID_W  host function ID
- cmd_data0, cmd_data1  in  CFU_REQ_DATA_W  host operands
- req_valid  out  1  CFU request valid
- req_ready  in  1  CFU request accepted
- req_func_id  out  CFU_FUNC_ID_W  CFU function ID
- req_id  out  CFU_REQ_RESP_ID_W  CFU request ID
- req_data0, req_data1  out  CFU_REQ_DATA_W  CFU operands
- resp_valid  in  1  CFU response valid (1-cycle pulse; no backpressure)
- resp_id  in  CFU_REQ_RESP_ID_W  CFU response ID
- resp_data  in  CFU_RESP_DATA_W  CFU response data
- resp_err, resp_err_id  in  1 / CFU_ERR_ID_W  CFU error flag and ID
- res_valid  out  1  host result valid
- res_ready  in  1  host result accepted
- res_data  out  CFU_RESP_DATA_W  result data
- res_err, res_err_id  out  1 / CFU_ERR_ID_W  forwarded CFU error
- res_timeout  out  1  no response within TIMEOUT_CYCLES
- res_id_mismatch  out  1  response ID differed from issued ID
- stray_resp  out  1  1-cycle pulse: resp_valid outside WAIT

Function
REQ-008 The block SHALL implement states IDLE, ISSUE, WAIT, HOLD, with at most one CFU request outstanding.
REQ-009 IDLE: cmd_ready=1 combinationally; on cmd_valid, the block SHALL register func_id/data0/data1 and go to ISSUE; req_valid first asserts on the next cycle.
REQ-010 cmd_ready SHALL be 1 only in IDLE.
REQ-011 ISSUE: req_valid=1 with req_func_id/req_data0/req_data1/req_id held stable until req_ready=1; on handshake, go to WAIT, clear the timer, and increment next_id modulo 2^CFU_REQ_RESP_ID_W (wraps max to 0).
REQ-012 req_id SHALL equal next_id during ISSUE; req_valid SHALL be 0 in every other state.
REQ-013 WAIT: the timer SHALL increment by 1 per cycle.
REQ-014 WAIT, resp_valid=1 and resp_id equal to the issued ID: capture resp_data/resp_err/resp_err_id; res_id_mismatch=0, res_timeout=0; go to HOLD.
REQ-015 WAIT, resp_valid=1 and resp_id not equal to the issued ID: capture as in REQ-014 but set res_id_mismatch=1; go to HOLD.
REQ-016 WAIT, timer=TIMEOUT_CYCLES-1 and resp_valid=0: set res_data=0, res_err=0, res_err_id=0, res_timeout=1; go to HOLD.
REQ-017 When resp_valid and the timeout coincide, the response SHALL win.
REQ-018 HOLD: res_valid=1 with result fields stable; on res_ready go to IDLE; cmd_ready SHALL remain 0 that cycle.
REQ-019 resp_valid in IDLE, ISSUE or HOLD (including late responses after a timeout) SHALL be ignored, SHALL NOT alter result fields, and SHALL pulse stray_resp one cycle later.
REQ-020 Minimum cmd-to-res latency SHALL be 3 cycles (req_ready already high, response the cycle after the request handshake).

Reset
REQ-021 While rst=1, asynchronously: state=IDLE, next_id=0, timer=0, req_valid=0, res_valid=0, stray_resp=0, res_timeout=0, res_id_mismatch=0, res_err=0, res_data=0, res_err_id=0, registered request fields=0.
REQ-022 Reset in any state SHALL abandon the outstanding request; responses after reset deassertion SHALL count as stray.

Verification
REQ-023 Responder with req_ready=1 returns data 7, ID echoed, one cycle after the handshake; command (func 0, 14, 21) -> req_id=0, res_data=7, flags 0, res_valid 3 cycles after cmd accept.
REQ-024 Hold req_ready=0 for 5 cycles -> req_valid and the payload stay stable for all 5 cycles; WAIT entered only after the handshake.
REQ-025 Issue 257 commands with CFU_REQ_RESP_ID_W=8 -> req_id sequence 0..255, 0; all results match.
REQ-026 Responder silent, TIMEOUT_CYCLES=8 -> res_timeout=1, res_data=0 at 8 cycles after the request handshake; a later resp_valid -> stray_resp pulse, result unchanged.
REQ-027 Response with resp_id=issued+1 and resp_err=1, resp_err_id=5 -> res_id_mismatch=1, res_err=1, res_err_id=5.
REQ-028 Assert rst during WAIT -> all outputs at reset values immediately; the next command uses req_id=0.
